bit_packer: RTL and testbench
=============================

# bit_packer

Parametrised MSB-first variable-length-code packer for the bitstream stage. It accumulates right-justified codes of 0..MAX_CODE_BITS bits and emits fixed-width big-endian output words. Valid/ready handshakes on both sides give backpressure. An explicit flush emits a zero-padded, byte-aligned final word marked last. The block sits between the entropy coders and the stream writer, and keeps a running count of emitted bytes.

## Interface
- MAX_CODE_BITS, default 32: maximum code length accepted per input beat (≥1).
- OUT_BYTES, default 4: output word width in bytes; W = 8*OUT_BYTES (≥1).
- Local: ACC_BITS = MAX_CODE_BITS + W. LW = clog2(MAX_CODE_BITS+1). NW = clog2(OUT_BYTES+1). FW = clog2(ACC_BITS+1).
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  a code is presented.
- in_ready  out  1  code is accepted on in_valid && in_ready.
- in_val  in  MAX_CODE_BITS  code, right-justified; bits at and above in_len are ignored (masked).
- in_len  in  LW  code length 0..MAX_CODE_BITS; 0 = accepted no-op.
- flush  in  1  one-cycle request: pad to byte boundary and emit remaining bits.
- flush_done  out  1  one-cycle pulse when the flush completes.
- out_valid  out  1  output word held.
- out_ready  in  1  output word consumed on out_valid && out_ready.
- out_data  out  W  packed bits, first bit at MSB, zero-padded.
- out_nbytes  out  NW  valid leading bytes in out_data (1..OUT_BYTES).
- out_last  out  1  final word of a flush.
- total_byte_size  out  32  running sum of out_nbytes over completed output handshakes; wraps mod 2^32.
- fill_level  out  FW  bits currently held in the accumulator (excludes the output register).

## Operation
- The accumulator is ACC_BITS wide and MSB-aligned; fill counts valid bits. An accepted code appends its low in_len bits directly below the existing bits, and fill increases by in_len.
- in_ready = (state==RUN) && (fill < W). It depends on registers only, with no path from in_valid or out_ready. This bound guarantees fill + in_len ≤ ACC_BITS.
- The output slot is free when !out_valid || out_ready.
- Full-word emit: when fill ≥ W and the slot is free, the top W bits are loaded into out_data. The accumulator then shifts left by W, fill decreases by W, out_nbytes = OUT_BYTES and out_valid = 1.
- Accept and full-word emit are mutually exclusive by construction, because accept needs fill < W and emit needs fill ≥ W.
- If the slot is free and there is nothing to emit, out_valid falls after the handshake.
- States:
  - RUN: accept codes and emit full words. If flush = 1, go to FLUSH. A code accepted in the same cycle as flush is included in the flush.
  - FLUSH: in_ready = 0.
    - If fill ≥ W, emit a full word, with out_last = 1 only if fill == W.
    - Otherwise, if 0 < fill < W and the slot is free, emit a partial word: out_data = top bits zero-padded, out_nbytes = ceil(fill/8), out_last = 1, fill = 0.
    - When the last word has been loaded, or on entry with fill == 0, go to RUN and pulse flush_done the next cycle.
- Flush with fill == 0 produces no output word, only flush_done.
- flush in FLUSH state is ignored. flush_done and out_last are never asserted outside a flush.
- After a flush the bit offset is 0, so the next stream starts byte-aligned.
- total_byte_size updates on the handshake cycle: += out_nbytes.

## Timing
- Reset (asynchronous, immediate):
  - state = RUN, fill = 0, accumulator = 0.
  - out_valid = 0, out_data = 0, out_nbytes = 0, out_last = 0, flush_done = 0, total_byte_size = 0, fill_level = 0.
  - in_ready = 1 in the first cycle after release.
- Reset mid-operation discards all held bits and any pending output word.
- Latency: a code accepted at edge N that brings fill to ≥ W has its word visible from edge N+1 when the slot is free. Reaching fill ≥ W costs one in_ready-low cycle.
- out_data, out_nbytes and out_last stay stable while out_valid && !out_ready.
- Under sustained backpressure, fill rises to a maximum of W-1+MAX_CODE_BITS. in_ready stays low until the slot frees.
- Flush latency from an empty pipeline with fill < W: flush at edge N, final word at N+1, flush_done at N+2.

## Test plan
- Default parameters; eight codes of in_len = 4, in_val = 1..8, then out_ready held high: out_data 0x12345678, out_nbytes 4, out_last 0; total_byte_size 4.
- Three codes of in_len = 3, in_val = 0b101, then flush: out_data 0xB6800000, out_nbytes 2, out_last 1; flush_done one cycle later; total_byte_size 2; fill_level 0.
- Junk above length: in_len = 4, in_val = 0xFFFFFFF5, sent eight times: out_data 0x55555555.
- Straddle under backpressure:
  - Stimulus: out_ready = 0; send in_len 28 = 0xABCDEF1, then in_len 32 = 0x2345678F, then in_len 4 = 0x0.
  - Expected: in_ready drops once fill reaches 60; out_data holds 0xABCDEF12 stable.
  - On out_ready = 1: next word 0x345678F0, with no loss.
- Flush with fill == 0: flush_done pulses two cycles later, out_valid never rises, total_byte_size unchanged.
- Reset mid-stream: deassert reset_n while out_valid = 1 and fill = 20. All outputs are 0 immediately; after release, in_ready = 1 and the next codes pack from bit 0.

Source files
------------

// File: rtl/bit_packer.sv
// bit_packer: MSB-first variable-length-code packer.
//
// Right-justified codes of 0..MAX_CODE_BITS bits are appended to an
// MSB-aligned accumulator. Whenever at least one full output word is held,
// the top W bits are moved into a registered output slot. A flush pads the
// remaining bits to a byte boundary and emits them as a final word marked
// last, then pulses flush_done. A running count of emitted bytes is kept.
//
// Ports:
//   clock, reset_n        rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake; in_ready depends on registers only
//   in_val, in_len        right-justified code and its length (0 = no-op)
//   flush                 one-cycle request to pad and emit the held bits
//   flush_done            one-cycle pulse when a flush has completed
//   out_valid/out_ready   output handshake
//   out_data              packed bits, first bit at MSB, zero-padded
//   out_nbytes            valid leading bytes in out_data
//   out_last              final word of a flush
//   total_byte_size       sum of out_nbytes over completed handshakes (wraps)
//   fill_level            bits currently held in the accumulator
module bit_packer #(
  parameter int MAX_CODE_BITS = 32,
  parameter int OUT_BYTES     = 4,
  localparam int W            = 8 * OUT_BYTES,
  localparam int ACC_BITS     = MAX_CODE_BITS + W,
  localparam int LW           = $clog2(MAX_CODE_BITS + 1),
  localparam int NW           = $clog2(OUT_BYTES + 1),
  localparam int FW           = $clog2(ACC_BITS + 1)
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [MAX_CODE_BITS-1:0] in_val,
  input  logic [LW-1:0]            in_len,
  input  logic                     flush,
  output logic                     flush_done,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [W-1:0]             out_data,
  output logic [NW-1:0]            out_nbytes,
  output logic                     out_last,
  output logic [31:0]              total_byte_size,
  output logic [FW-1:0]            fill_level
);

  typedef enum logic {
    S_RUN,
    S_FLUSH
  } state_t;

  localparam logic [FW-1:0] W_F     = FW'(W);
  localparam logic [FW-1:0] ACC_F   = FW'(ACC_BITS);
  localparam logic [LW-1:0] LEN_MAX = LW'(MAX_CODE_BITS);

  state_t              r_state;
  logic [ACC_BITS-1:0] r_acc;
  logic [FW-1:0]       r_fill;
  logic                r_out_valid;
  logic [W-1:0]        r_out_data;
  logic [NW-1:0]       r_out_nbytes;
  logic                r_out_last;
  logic                r_done_pend;
  logic                r_flush_done;
  logic [31:0]         r_total;

  logic [LW-1:0]            w_len;
  logic [MAX_CODE_BITS-1:0] w_code;
  logic [FW-1:0]            w_shamt;
  logic [ACC_BITS-1:0]      w_ins;
  logic                     w_in_ready;
  logic                     w_accept;
  logic                     w_slot_free;
  logic                     w_has_word;
  logic                     w_emit_full;
  logic                     w_emit_part;
  logic [NW-1:0]            w_part_nbytes;
  logic                     w_flush_end;

  // Out-of-range lengths are clamped so the insert can never overrun the
  // accumulator.
  assign w_len  = (in_len > LEN_MAX) ? LEN_MAX : in_len;
  // A shift by the full code width yields zero, so a full-length code keeps
  // every bit of in_val.
  assign w_code = in_val & ~({MAX_CODE_BITS{1'b1}} << w_len);

  // The new code lands directly below the fill bits already held. Because
  // in_ready requires fill < W, fill + len never exceeds ACC_BITS.
  assign w_shamt = ACC_F - r_fill - FW'(w_len);
  assign w_ins   = {{W{1'b0}}, w_code} << w_shamt;

  assign w_in_ready  = (r_state == S_RUN) && (r_fill < W_F);
  assign w_accept    = in_valid && w_in_ready;
  assign w_slot_free = !r_out_valid || out_ready;

  // Accept (fill < W) and full-word emit (fill >= W) never coincide.
  assign w_has_word  = (r_fill >= W_F);
  assign w_emit_full = w_has_word && w_slot_free;
  assign w_emit_part = (r_state == S_FLUSH) && !w_has_word &&
                       (r_fill != '0) && w_slot_free;

  // ceil(fill/8), computed one bit wider so the +7 cannot wrap.
  assign w_part_nbytes = NW'(({1'b0, r_fill} + (FW+1)'(7)) >> 3);

  // The flush ends once the last held bits are loaded into the output slot,
  // or immediately when nothing is held.
  assign w_flush_end = (r_state == S_FLUSH) &&
                       ((r_fill == '0) || w_emit_part ||
                        (w_emit_full && (r_fill == W_F)));

  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others, independent of
  // statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_RUN;
      r_acc        <= '0;
      r_fill       <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_nbytes <= '0;
      r_out_last   <= 1'b0;
      r_done_pend  <= 1'b0;
      r_flush_done <= 1'b0;
      r_total      <= '0;
    end else begin
      // flush_done trails the end of the flush by one cycle.
      r_done_pend  <= 1'b0;
      r_flush_done <= r_done_pend;

      // Accumulator: append, drop one emitted word, or clear after the
      // final partial word.
      if (w_accept) begin
        r_acc  <= r_acc | w_ins;
        r_fill <= r_fill + FW'(w_len);
      end else if (w_emit_full) begin
        r_acc  <= r_acc << W;
        r_fill <= r_fill - W_F;
      end else if (w_emit_part) begin
        r_acc  <= '0;
        r_fill <= '0;
      end

      // Output slot: bits below fill are always zero, so the top W bits
      // are already correctly zero-padded for a partial word.
      if (w_emit_full || w_emit_part) begin
        r_out_valid  <= 1'b1;
        r_out_data   <= r_acc[ACC_BITS-1 -: W];
        r_out_nbytes <= w_emit_full ? NW'(OUT_BYTES) : w_part_nbytes;
        r_out_last   <= w_emit_part ||
                        ((r_state == S_FLUSH) && (r_fill == W_F));
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end

      if (r_out_valid && out_ready) begin
        r_total <= r_total + 32'(r_out_nbytes);
      end

      // A code accepted in the same cycle as flush is part of the flush.
      case (r_state)
        S_RUN: begin
          if (flush) begin
            r_state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (w_flush_end) begin
            r_state     <= S_RUN;
            r_done_pend <= 1'b1;
          end
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

  assign in_ready        = w_in_ready;
  assign flush_done      = r_flush_done;
  assign out_valid       = r_out_valid;
  assign out_data        = r_out_data;
  assign out_nbytes      = r_out_nbytes;
  assign out_last        = r_out_last;
  assign total_byte_size = r_total;
  assign fill_level      = r_fill;

endmodule

// File: tb/tb_bit_packer.sv
// tb_bit_packer: directed scenarios plus a randomized run checked against a
// bit-queue reference model of the packed stream.
module tb_bit_packer;

  localparam int MAXB = 32;
  localparam int LW   = 6;
  localparam int NW   = 3;
  localparam int FW   = 7;

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [MAXB-1:0] in_val = '0;
  logic [LW-1:0]   in_len = '0;
  logic            flush = 1'b0;
  logic            flush_done;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [31:0]     out_data;
  logic [NW-1:0]   out_nbytes;
  logic            out_last;
  logic [31:0]     total_byte_size;
  logic [FW-1:0]   fill_level;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  nbytes;
    logic [1:0]  mode;   // 0: last must be 0, 1: last must be 1, 2: either
  } exp_t;

  bit_packer #(.MAX_CODE_BITS(32), .OUT_BYTES(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_val(in_val), .in_len(in_len),
    .flush(flush), .flush_done(flush_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_nbytes(out_nbytes), .out_last(out_last),
    .total_byte_size(total_byte_size), .fill_level(fill_level)
  );

  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_val   = '0;
    in_len   = '0;
    flush    = 1'b0;
  endtask

  task automatic apply_reset();
    idle();
    out_ready = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    #3;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic send_code(input logic [31:0] v, input int l);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_val   = v;
    in_len   = LW'(l);
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL send_timeout: in_ready=%b after %0d cycles, expected 1", in_ready, n);
    end
    tick();
    idle();
  endtask

  task automatic wait_out(input string name);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL %s_timeout: out_valid=%b after %0d cycles, expected 1", name, out_valid, n);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_nbytes !== 3'd0 ||
        out_last !== 1'b0 || flush_done !== 1'b0 || total_byte_size !== 32'h0 ||
        fill_level !== 7'd0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b data=%h nbytes=%0d last=%b done=%b total=%0d fill=%0d, expected all 0",
               out_valid, out_data, out_nbytes, out_last, flush_done, total_byte_size, fill_level);
    end
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_basic();
    apply_reset();
    for (int i = 1; i <= 8; i++) send_code(32'(i), 4);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_full_fill: in_ready=%b out_valid=%b, expected 0 0", in_ready, out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h12345678 || out_nbytes !== 3'd4 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL basic_word: valid=%b data=%h nbytes=%0d last=%b, expected 1 12345678 4 0",
               out_valid, out_data, out_nbytes, out_last);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (total_byte_size !== 32'd4 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_total: total=%0d valid=%b, expected 4 0", total_byte_size, out_valid);
    end
  endtask

  task automatic test_flush();
    apply_reset();
    for (int i = 0; i < 3; i++) send_code(32'h5, 3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_enter: valid=%b in_ready=%b, expected 0 0", out_valid, in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hB6800000 || out_nbytes !== 3'd2 ||
        out_last !== 1'b1 || flush_done !== 1'b0 || fill_level !== 7'd0) begin
      errors++;
      $display("FAIL flush_word: valid=%b data=%h nbytes=%0d last=%b done=%b fill=%0d, expected 1 b6800000 2 1 0 0",
               out_valid, out_data, out_nbytes, out_last, flush_done, fill_level);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (flush_done !== 1'b1 || total_byte_size !== 32'd2 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_done: done=%b total=%0d valid=%b, expected 1 2 0", flush_done, total_byte_size, out_valid);
    end
    tick();
    checks++;
    if (flush_done !== 1'b0) begin
      errors++;
      $display("FAIL flush_done_pulse: done=%b expected 0", flush_done);
    end
  endtask

  task automatic test_junk();
    apply_reset();
    out_ready = 1'b1;
    repeat (8) send_code(32'hFFFFFFF5, 4);
    wait_out("junk");
    checks++;
    if (out_data !== 32'h55555555 || out_nbytes !== 3'd4 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL junk_word: data=%h nbytes=%0d last=%b, expected 55555555 4 0", out_data, out_nbytes, out_last);
    end
    tick();
  endtask

  task automatic test_straddle();
    apply_reset();
    send_code(32'h0ABCDEF1, 28);
    send_code(32'h2345678F, 32);
    checks++;
    if (fill_level !== 7'd60 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL straddle_fill60: fill=%0d in_ready=%b, expected 60 0", fill_level, in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hABCDEF12 || fill_level !== 7'd28 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL straddle_first: valid=%b data=%h fill=%0d in_ready=%b, expected 1 abcdef12 28 1",
               out_valid, out_data, fill_level, in_ready);
    end
    send_code(32'h0, 4);
    repeat (3) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'hABCDEF12 || in_ready !== 1'b0 || fill_level !== 7'd32) begin
        errors++;
        $display("FAIL straddle_hold: valid=%b data=%h in_ready=%b fill=%0d, expected 1 abcdef12 0 32",
                 out_valid, out_data, in_ready, fill_level);
      end
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h345678F0 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL straddle_second: valid=%b data=%h last=%b, expected 1 345678f0 0", out_valid, out_data, out_last);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || total_byte_size !== 32'd8) begin
      errors++;
      $display("FAIL straddle_total: valid=%b total=%0d, expected 0 8", out_valid, total_byte_size);
    end
  endtask

  task automatic test_flush_empty();
    logic exp_done [4];
    apply_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send_code(32'(i), 4);
    wait_out("flush_empty_pre");
    tick();
    exp_done = '{1'b0, 1'b0, 1'b1, 1'b0};
    flush = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      flush = 1'b0;
      checks++;
      if (flush_done !== exp_done[c] || out_valid !== 1'b0 || total_byte_size !== 32'd4) begin
        errors++;
        $display("FAIL flush_empty_c%0d: done=%b valid=%b total=%0d, expected %b 0 4",
                 c, flush_done, out_valid, total_byte_size, exp_done[c]);
      end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    send_code(32'h12345678, 32);
    tick();
    send_code(32'h000ABCDE, 20);
    checks++;
    if (out_valid !== 1'b1 || fill_level !== 7'd20) begin
      errors++;
      $display("FAIL rstmid_setup: valid=%b fill=%0d, expected 1 20", out_valid, fill_level);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_nbytes !== 3'd0 || out_last !== 1'b0 ||
        flush_done !== 1'b0 || total_byte_size !== 32'h0 || fill_level !== 7'd0) begin
      errors++;
      $display("FAIL rstmid_outputs: valid=%b data=%h nbytes=%0d last=%b done=%b total=%0d fill=%0d, expected all 0",
               out_valid, out_data, out_nbytes, out_last, flush_done, total_byte_size, fill_level);
    end
    #2;
    reset_n = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_in_ready: got %b expected 1", in_ready);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send_code(32'(9 - i), 4);
    wait_out("rstmid");
    checks++;
    if (out_data !== 32'h98765432) begin
      errors++;
      $display("FAIL rstmid_word: data=%h expected 98765432", out_data);
    end
    tick();
  endtask

  task automatic test_random();
    bit          q[$];
    exp_t        exp_q[$];
    exp_t        e;
    logic [31:0] d;
    logic [31:0] exp_total;
    int          seg_words, flushes, dones, l;
    bit          busy, final_sent, drain;
    apply_reset();
    exp_total = 0; seg_words = 0; flushes = 0; dones = 0;
    busy = 1'b0; final_sent = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      drain = (cyc >= 2500);
      if (flush_done) begin
        checks++;
        if (!busy) begin
          errors++;
          $display("FAIL rand_spurious_done: flush_done=1 at cycle %0d with no flush pending", cyc);
        end
        dones++;
        busy = 1'b0;
      end
      in_valid  = !drain && ($urandom_range(0, 3) != 0);
      in_val    = $urandom();
      l         = $urandom_range(0, 32);
      in_len    = LW'(l);
      out_ready = drain || ($urandom_range(0, 9) < 7);
      flush     = 1'b0;
      if (!busy && ((!drain && $urandom_range(0, 39) == 0) || (drain && !final_sent))) begin
        flush = 1'b1;
        if (drain) final_sent = 1'b1;
      end
      // Model: the stream is the concatenation of accepted codes, cut into
      // 32-bit words, with each flush padding its segment to a byte.
      if (in_valid && in_ready) begin
        for (int b = l - 1; b >= 0; b--) q.push_back(in_val[b]);
        while (q.size() >= 32) begin
          d = '0;
          for (int b = 0; b < 32; b++) d = {d[30:0], q.pop_front()};
          exp_q.push_back('{data: d, nbytes: 3'd4, mode: 2'd0});
          seg_words++;
        end
      end
      if (flush) begin
        while (q.size() % 8 != 0) q.push_back(1'b0);
        if (q.size() > 0) begin
          e.nbytes = 3'(q.size() / 8);
          d = '0;
          for (int b = 0; b < 32; b++) d = {d[30:0], (q.size() > 0) ? q.pop_front() : 1'b0};
          e.data = d;
          e.mode = 2'd1;
          exp_q.push_back(e);
        end else if (seg_words > 0 && exp_q.size() > 0) begin
          e = exp_q.pop_back();
          e.mode = 2'd2;
          exp_q.push_back(e);
        end
        seg_words = 0;
        busy = 1'b1;
        flushes++;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rand_extra_word: data=%h nbytes=%0d, expected no word", out_data, out_nbytes);
        end else begin
          e = exp_q.pop_front();
          exp_total = exp_total + 32'(e.nbytes);
          if (out_data !== e.data || out_nbytes !== e.nbytes) begin
            errors++;
            $display("FAIL rand_word: data=%h nbytes=%0d, expected %h %0d", out_data, out_nbytes, e.data, e.nbytes);
          end
          if (e.mode != 2'd2) begin
            checks++;
            if (out_last !== e.mode[0]) begin
              errors++;
              $display("FAIL rand_last: last=%b expected %b", out_last, e.mode[0]);
            end
          end
        end
      end
      checks++;
      if (fill_level > 7'd63) begin
        errors++;
        $display("FAIL rand_fill_max: fill=%0d expected <= 63", fill_level);
      end
      tick();
    end
    idle();
    checks++;
    if (exp_q.size() != 0 || q.size() != 0 || out_valid !== 1'b0 || fill_level !== 7'd0) begin
      errors++;
      $display("FAIL rand_drain: pending=%0d model_bits=%0d valid=%b fill=%0d, expected 0 0 0 0",
               exp_q.size(), q.size(), out_valid, fill_level);
    end
    checks++;
    if (total_byte_size !== exp_total) begin
      errors++;
      $display("FAIL rand_total: total=%0d expected %0d", total_byte_size, exp_total);
    end
    checks++;
    if (dones != flushes) begin
      errors++;
      $display("FAIL rand_flush_count: flush_done pulses=%0d expected %0d", dones, flushes);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_flush();
    test_junk();
    test_straddle();
    test_flush_empty();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
